cnn_layer_sequencer: RTL

Top-level sequencer for the conv2d → max_pool → fully_connected forward pass. It turns a single `start` request into the ordered layer enables, and advances on each layer's done edge. It also guards every layer with a watchdog timeout and reports busy, done, error and a cycle count. The block replaces the hand-sequenced enables currently driven from the bench, and is the control point the CPU/host interface will attach to.

---
 rtl/cnn_pkg.sv | 48 ++++
 rtl/cnn_layer_sequencer_if.sv | 36 +++
 rtl/layer_watchdog.sv | 31 +++
 rtl/cnn_layer_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the CNN layer sequencer.
//   seq_state_t      sequencer state encoding
//   LAYER_*          layer codes reported on err_layer
//   DEFAULT_TIMEOUT  default per-layer watchdog limit in cycles
//   is_layer()       state is one of CONV/POOL/FC
//   layer_code()     layer code of a layer state
//   next_layer()     state that follows a completed layer
package cnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CONV = 3'd1,
    ST_POOL = 3'd2,
    ST_FC   = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } seq_state_t;

  localparam logic [1:0] LAYER_NONE = 2'd0;
  localparam logic [1:0] LAYER_CONV = 2'd1;
  localparam logic [1:0] LAYER_POOL = 2'd2;
  localparam logic [1:0] LAYER_FC   = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT = 32'd16777216;

  function automatic logic is_layer(input seq_state_t s);
    return (s == ST_CONV) || (s == ST_POOL) || (s == ST_FC);
  endfunction

  function automatic logic [1:0] layer_code(input seq_state_t s);
    case (s)
      ST_CONV: return LAYER_CONV;
      ST_POOL: return LAYER_POOL;
      ST_FC:   return LAYER_FC;
      default: return LAYER_NONE;
    endcase
  endfunction

  function automatic seq_state_t next_layer(input seq_state_t s);
    case (s)
      ST_CONV: return ST_POOL;
      ST_POOL: return ST_FC;
      ST_FC:   return ST_DONE;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// cnn_layer_sequencer_if: host/layer-side bundle of the sequencer.
//   master: drives start/abort/err_clear and the layer done levels,
//           observes enables and status.
//   slave : the sequencer itself.
//   CNT_WIDTH sets the width of cycle_count.
interface cnn_layer_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 start;
  logic                 abort;
  logic                 err_clear;
  logic                 conv_done;
  logic                 pool_done;
  logic                 fc_done;
  logic                 conv_enable;
  logic                 input_valid;
  logic                 pool_enable;
  logic                 fc_enable;
  logic                 busy;
  logic                 run_done;
  logic                 error;
  logic [1:0]           err_layer;
  logic [CNT_WIDTH-1:0] cycle_count;

  modport master (
    output start, abort, err_clear, conv_done, pool_done, fc_done,
    input  conv_enable, input_valid, pool_enable, fc_enable,
           busy, run_done, error, err_layer, cycle_count
  );

  modport slave (
    input  start, abort, err_clear, conv_done, pool_done, fc_done,
    output conv_enable, input_valid, pool_enable, fc_enable,
           busy, run_done, error, err_layer, cycle_count
  );
endinterface

// File: rtl/layer_watchdog.sv
// layer_watchdog: per-layer timeout counter.
//   clk, reset : clock, synchronous active-high reset
//   clr        : a new layer is being entered this cycle
//   run        : sequencer currently sits in a layer state
//   timeout    : this is the last permitted cycle of the layer
// The counter reads 0 in the first cycle of every layer and counts up
// while the layer runs; timeout asserts when it reaches TIMEOUT_CYCLES-1,
// so the sequencer leaves for ERR exactly TIMEOUT_CYCLES cycles after entry.
module layer_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic timeout
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Held at 0 outside a layer, so entry from IDLE needs no explicit clear;
  // clr covers back-to-back layer handoffs.
  always_ff @(posedge clk) begin
    if (reset || clr || !run) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign timeout = run && (cnt == LAST);
endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: drives conv2d -> max_pool -> fully_connected from a
// single start request, advancing on each layer's done rising edge.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of cnn_layer_sequencer_if
//     in : start, abort, err_clear, conv_done, pool_done, fc_done
//     out: conv_enable, input_valid, pool_enable, fc_enable, busy,
//          run_done, error, err_layer, cycle_count
// Every output is a register loaded from the next state, so enables
// switch on the same edge as the state with no overlap or gap.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  cnn_layer_sequencer_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  seq_state_t state, nxt;
  logic conv_q, pool_q, fc_q;
  logic conv_rise, pool_rise, fc_rise;
  logic layer_rise, timeout, wd_clr, in_layer;

  // The _q copies track the level every cycle, so a done that is already
  // high when its layer starts never looks like an edge.
  assign conv_rise = bus.conv_done & ~conv_q;
  assign pool_rise = bus.pool_done & ~pool_q;
  assign fc_rise   = bus.fc_done   & ~fc_q;
  assign in_layer  = is_layer(state);

  // Only the active layer's edge matters; the others are dropped.
  always_comb begin
    layer_rise = 1'b0;
    case (state)
      ST_CONV: layer_rise = conv_rise;
      ST_POOL: layer_rise = pool_rise;
      ST_FC:   layer_rise = fc_rise;
      default: layer_rise = 1'b0;
    endcase
  end

  // Priority inside a layer: abort, then done edge, then timeout.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (bus.start && !bus.abort) nxt = ST_CONV;
      ST_CONV, ST_POOL, ST_FC: begin
        if (bus.abort)      nxt = ST_IDLE;
        else if (layer_rise) nxt = next_layer(state);
        else if (timeout)   nxt = ST_ERR;
      end
      ST_DONE: nxt = ST_IDLE;
      ST_ERR:  if (bus.err_clear) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  assign wd_clr = is_layer(nxt) && (nxt != state);

  layer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .run     (in_layer),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      conv_q          <= 1'b0;
      pool_q          <= 1'b0;
      fc_q            <= 1'b0;
      bus.conv_enable <= 1'b0;
      bus.input_valid <= 1'b0;
      bus.pool_enable <= 1'b0;
      bus.fc_enable   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.run_done    <= 1'b0;
      bus.error       <= 1'b0;
      bus.err_layer   <= LAYER_NONE;
      bus.cycle_count <= '0;
    end else begin
      conv_q          <= bus.conv_done;
      pool_q          <= bus.pool_done;
      fc_q            <= bus.fc_done;
      state           <= nxt;
      bus.conv_enable <= (nxt == ST_CONV);
      bus.input_valid <= (nxt == ST_CONV);
      bus.pool_enable <= (nxt == ST_POOL);
      bus.fc_enable   <= (nxt == ST_FC);
      bus.busy        <= is_layer(nxt);
      bus.run_done    <= (nxt == ST_DONE);
      bus.error       <= (nxt == ST_ERR);

      // Latch the failing layer on ERR entry, hold in ERR, clear on exit.
      if (nxt != ST_ERR)        bus.err_layer <= LAYER_NONE;
      else if (state != ST_ERR) bus.err_layer <= layer_code(state);

      // Counts cycles spent in layer states; keeps its value once the run
      // ends so the host can read it back.
      if (state == ST_IDLE && nxt == ST_CONV)
        bus.cycle_count <= '0;
      else if (in_layer && bus.cycle_count != CNT_MAX)
        bus.cycle_count <= bus.cycle_count + 1'b1;
    end
  end
endmodule
